// File: rtl/sequential_subtractor50_11_if.sv
// Operand/result handshake bundle for the 50-bit minus 39-bit sequential subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface sequential_subtractor50_11_if;
   logic        in_valid;
   logic        in_ready;
   logic [49:0] A;
   logic [38:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [49:0] Diff;
   logic        Borrow;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Diff, Borrow
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Diff, Borrow
   );
endinterface

// File: rtl/sequential_subtractor50_11.sv
// Computes A - {11'b0,B} one SLICE_W-bit slice per cycle with a rippled borrow; result after N=50/SLICE_W cycles.
// One operation in flight: in_ready only in IDLE, and the result holds in DONE for as long as out_ready stays low.
module sequential_subtractor50_11 #(
   parameter int SLICE_W = 10
) (
   input logic                   clk,
   input logic                   rst,
   sequential_subtractor50_11_if.slave bus
);
   localparam int N   = 50 / SLICE_W;
   localparam int K_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic               borrow_q, borrow_d;
   logic [49:0]        a_q, a_d;
   logic [49:0]        b_q, b_d;
   logic [49:0]        work_q, work_d;
   logic [49:0]        diff_q, diff_d;
   logic               res_borrow_q, res_borrow_d;
   logic               out_valid_q, out_valid_d;

   logic [SLICE_W-1:0] a_slice;
   logic [SLICE_W-1:0] b_slice;
   logic [SLICE_W:0]   slice_res;

   always_comb begin
      a_slice   = a_q[int'(k_q) * SLICE_W +: SLICE_W];
      b_slice   = b_q[int'(k_q) * SLICE_W +: SLICE_W];
      // One extra bit: its MSB is the borrow out of this slice.
      slice_res = {1'b0, a_slice} - {1'b0, b_slice} - {{SLICE_W{1'b0}}, borrow_q};

      state_d      = state_q;
      k_d          = k_q;
      borrow_d     = borrow_q;
      a_d          = a_q;
      b_d          = b_q;
      work_d       = work_q;
      diff_d       = diff_q;
      res_borrow_d = res_borrow_q;
      out_valid_d  = out_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d  = BUSY;
               a_d      = bus.A;
               b_d      = {11'b0, bus.B};
               k_d      = '0;
               borrow_d = 1'b0;
            end
         end
         BUSY: begin
            work_d[int'(k_q) * SLICE_W +: SLICE_W] = slice_res[SLICE_W-1:0];
            borrow_d = slice_res[SLICE_W];
            k_d      = k_q + 1'b1;
            if (k_q == K_W'(N - 1)) begin
               // Outputs load only here, so consumers never see a partial difference.
               state_d      = DONE;
               k_d          = '0;
               diff_d       = work_d;
               res_borrow_d = slice_res[SLICE_W];
               out_valid_d  = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         k_q          <= '0;
         borrow_q     <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         work_q       <= '0;
         diff_q       <= '0;
         res_borrow_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         borrow_q     <= borrow_d;
         a_q          <= a_d;
         b_q          <= b_d;
         work_q       <= work_d;
         diff_q       <= diff_d;
         res_borrow_q <= res_borrow_d;
         out_valid_q  <= out_valid_d;
      end
   end

   // Gated by rst so nothing is offered while reset is held.
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.Diff      = diff_q;
   assign bus.Borrow    = res_borrow_q;
endmodule

// File: tb/tb_sequential_subtractor50_11.sv
// Directed bench for the sequential subtractor: vector table on the SLICE_W=10 instance,
// plus backpressure, reset-abort and SLICE_W=25 sequences.
module tb_sequential_subtractor50_11;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   sequential_subtractor50_11_if if10();
   sequential_subtractor50_11_if if25();

   sequential_subtractor50_11 #(.SLICE_W(10)) dut10 (.clk(clk), .rst(rst), .bus(if10));
   sequential_subtractor50_11 #(.SLICE_W(25)) dut25 (.clk(clk), .rst(rst), .bus(if25));

   typedef struct {
      logic [49:0] a;
      logic [38:0] b;
      logic [49:0] diff;
      logic        borrow;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [49:0] a, input logic [38:0] b,
                         input logic [49:0] exp_d, input logic exp_b, input string tag);
      int lat;
      int w;
      w = 0;
      while (!if10.in_ready && w < 50) begin
         step();
         w++;
      end
      if10.A = a;
      if10.B = b;
      if10.in_valid  = 1'b1;
      if10.out_ready = 1'b1;
      step();
      if10.in_valid = 1'b0;
      if10.A = ~a;
      if10.B = ~b;
      check({tag, "_busy_in_ready"}, 64'(if10.in_ready), 64'd0);
      lat = 0;
      while (!if10.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd5);
      check({tag, "_diff"}, 64'(if10.Diff), 64'(exp_d));
      check({tag, "_borrow"}, 64'(if10.Borrow), 64'(exp_b));
      step();
      check({tag, "_post_out_valid"}, 64'(if10.out_valid), 64'd0);
      check({tag, "_post_in_ready"}, 64'(if10.in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      int hits;

      vecs[0] = '{a: 50'h3FFFFFFFFFFFF, b: 39'h7FFFFFFFFF, diff: 50'h3FF8000000000, borrow: 1'b0};
      vecs[1] = '{a: 50'h0,             b: 39'h1,          diff: 50'h3FFFFFFFFFFFF, borrow: 1'b1};
      vecs[2] = '{a: 50'h10000000000,   b: 39'h1,          diff: 50'h0FFFFFFFFFF,   borrow: 1'b0};
      vecs[3] = '{a: 50'h12345,         b: 39'h12345,      diff: 50'h0,             borrow: 1'b0};
      vecs[4] = '{a: 50'h155,           b: 39'h2AA,        diff: 50'h3FFFFFFFFFEAB, borrow: 1'b1};
      vecs[5] = '{a: 50'h8000000000,    b: 39'h7FFFFFFFFF, diff: 50'h1,             borrow: 1'b0};
      vecs[6] = '{a: 50'h3FF,           b: 39'h400,        diff: 50'h3FFFFFFFFFFFF, borrow: 1'b1};
      vecs[7] = '{a: 50'h2000000000000, b: 39'h4000000001, diff: 50'h1FFBFFFFFFFFF, borrow: 1'b0};

      rst = 1'b1;
      if10.in_valid = 1'b0; if10.out_ready = 1'b0; if10.A = '0; if10.B = '0;
      if25.in_valid = 1'b0; if25.out_ready = 1'b0; if25.A = '0; if25.B = '0;
      repeat (3) step();
      check("rst_in_ready", 64'(if10.in_ready), 64'd0);
      check("rst_out_valid", 64'(if10.out_valid), 64'd0);
      check("rst_diff", 64'(if10.Diff), 64'd0);
      check("rst_borrow", 64'(if10.Borrow), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(if10.in_ready), 64'd1);

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));

      // Backpressure: result must hold and further operands must be ignored.
      if10.A = 50'd100; if10.B = 39'd58; if10.in_valid = 1'b1; if10.out_ready = 1'b0;
      step();
      if10.A = 50'd999; if10.B = 39'd1;
      lat = 0;
      while (!if10.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("bp_latency", 64'(lat), 64'd5);
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("bp_valid_%0d", i), 64'(if10.out_valid), 64'd1);
         check($sformatf("bp_diff_%0d", i), 64'(if10.Diff), 64'd42);
         check($sformatf("bp_in_ready_%0d", i), 64'(if10.in_ready), 64'd0);
      end
      if10.out_ready = 1'b1;
      if10.in_valid  = 1'b0;
      step();
      check("bp_release_valid", 64'(if10.out_valid), 64'd0);
      check("bp_release_in_ready", 64'(if10.in_ready), 64'd1);

      // Reset abort during the third BUSY cycle.
      if10.A = 50'd5; if10.B = 39'd3; if10.in_valid = 1'b1;
      step();
      if10.in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check("abort_out_valid", 64'(if10.out_valid), 64'd0);
      check("abort_diff", 64'(if10.Diff), 64'd0);
      check("abort_borrow", 64'(if10.Borrow), 64'd0);
      rst = 1'b0;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (if10.out_valid) hits++;
      end
      check("abort_no_result", 64'(hits), 64'd0);
      run_op(50'd7, 39'd2, 50'd5, 1'b0, "fresh");

      // SLICE_W=25 instance, in_valid left high through BUSY and DONE.
      if25.A = 50'h2000000; if25.B = 39'd1; if25.in_valid = 1'b1; if25.out_ready = 1'b0;
      step();
      if25.A = 50'h3FFFFFFFFFFFF; if25.B = 39'd5;
      lat = 0;
      while (!if25.out_valid && lat < 50) begin
         step();
         lat++;
      end
      check("s25_latency", 64'(lat), 64'd2);
      check("s25_diff", 64'(if25.Diff), 64'h1FFFFFF);
      check("s25_borrow", 64'(if25.Borrow), 64'd0);
      repeat (2) step();
      check("s25_hold_valid", 64'(if25.out_valid), 64'd1);
      check("s25_hold_diff", 64'(if25.Diff), 64'h1FFFFFF);
      check("s25_hold_in_ready", 64'(if25.in_ready), 64'd0);
      if25.out_ready = 1'b1;
      step();
      if25.in_valid = 1'b0;
      check("s25_release_valid", 64'(if25.out_valid), 64'd0);
      check("s25_release_in_ready", 64'(if25.in_ready), 64'd1);
      hits = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (if25.out_valid) hits++;
      end
      check("s25_no_extra", 64'(hits), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sequential_subtractor50_11.md
# sequential_subtractor50_11

Multi-cycle unsigned subtractor that computes the 50-bit difference A − B. B is a 39-bit operand zero-extended by 11 bits. It is the inverse-direction companion to the 50-bit + 39-bit custom adder in the accumulation datapath, and is used to un-accumulate or compare partial products. The block processes the operands in SLICE_W-bit slices over several cycles, carrying the borrow between slices. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake.

## Interface
- SLICE_W, default 10: slice width in bits. Legal values are 5, 10, 25 and 50 (must divide 50). N = 50/SLICE_W is the slice count.
- clk  input  1: single clock; all logic is rising-edge triggered.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: operands A and B are valid.
- in_ready  output  1: the block can accept operands.
- A  input  50: minuend, unsigned.
- B  input  39: subtrahend, unsigned; zero-extended to 50 bits internally.
- out_valid  output  1: Diff and Borrow are valid.
- out_ready  input  1: the consumer accepts the result.
- Diff  output  50: (A − {11'b0,B}) mod 2^50.
- Borrow  output  1: 1 when A < {11'b0,B}, i.e. the final borrow-out.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - When in_valid is high, capture A and the zero-extended B, clear the slice index k and the borrow register, and go to BUSY.
- BUSY:
  - Each cycle computes slice k: bits [k·SLICE_W +: SLICE_W] of A − B − borrow_in.
  - Store the slice result into a working register and update the borrow with the slice borrow-out.
  - k increments each cycle.
  - After slice N−1: copy the working register to Diff, the final borrow to Borrow, and go to DONE.
  - in_ready = 0 throughout.
- DONE:
  - out_valid = 1.
  - Diff and Borrow are held stable until out_valid && out_ready.
  - On that handshake, go to IDLE.
  - in_valid is ignored in DONE.
- Width rules:
  - Slice arithmetic is SLICE_W+1 bits wide; the MSB of the slice result is the borrow-out.
  - There is no sign interpretation; Diff wraps modulo 2^50.
- Diff and Borrow are output registers. They change only on the transition BUSY→DONE and never show partial results.
- Inputs A and B may change freely after acceptance. The block uses only its captured copies.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 0 while rst is high; in_ready = 1 from the first cycle after rst deasserts.
  - out_valid = 0, Diff = 0, Borrow = 0, k = 0, internal borrow = 0.
- Acceptance happens at rising edge E0, where in_valid && in_ready.
- BUSY occupies the cycles after E0 through E0+N.
- out_valid rises after edge E0+N; latency is N cycles (5 for the default).
- Throughput:
  - Minimum initiation interval is N+2 cycles when out_ready is held high.
  - Cycle breakdown: one DONE cycle with the handshake, then one IDLE cycle before the next acceptance.
  - The output handshake and the next input acceptance never occur in the same cycle.
- Backpressure: DONE persists indefinitely while out_ready = 0, with Diff and Borrow unchanged.
- Boundary conditions:
  - A = B gives Diff = 0, Borrow = 0.
  - A borrow chain spanning every slice must propagate correctly; one slice per cycle, with no early termination.
- Reset mid-operation:
  - rst in BUSY or DONE aborts the operation.
  - The next cycle is IDLE with out_valid = 0, and Diff and Borrow cleared.
  - No result from the aborted operation is ever presented.
- rst has priority over every handshake in the same cycle.

## Test plan
- A=0x3FFFFFFFFFFFF, B=0x7FFFFFFFFF, out_ready=1 -> out_valid rises exactly 5 cycles after acceptance; Diff=0x3FF8000000000, Borrow=0.
- A=0, B=1 -> Diff=0x3FFFFFFFFFFFF, Borrow=1 (borrow ripples through all 5 slices).
- A=0x10000000000, B=1 -> Diff=0x0FFFFFFFFFF, Borrow=0. A=0x12345, B=0x12345 -> Diff=0, Borrow=0.
- Backpressure: A=100, B=58, out_ready=0 for 6 cycles after out_valid rises.
  - Required: Diff=42 and out_valid held stable throughout, and in_ready=0 throughout.
  - Release out_ready -> one-cycle handshake, IDLE next cycle, in_ready=1.
- Reset abort: accept A=5, B=3, assert rst in the 3rd BUSY cycle.
  - Required: next cycle out_valid=0, Diff=0, Borrow=0, and no out_valid appears for that operation.
  - A fresh operation A=7, B=2 then yields Diff=5.
- SLICE_W=25 instance: A=0x2000000, B=1 -> out_valid 2 cycles after acceptance; Diff=0x1FFFFFF, Borrow=0. in_valid held high during BUSY/DONE causes no extra acceptance.
